// File: rtl/noc_pkg.sv
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared defaults and the ejection-handshake state encoding for
//                the local ejection port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

   localparam int DATA_WIDTH_DEF = 32;  // packet width in bits
   localparam int DEPTH_DEF      = 4;   // ejection buffer entries

   // Collector handshake states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } eject_state_e;

endpackage : noc_pkg

`default_nettype wire

// File: rtl/local_eject_port_if.sv
// ============================================================================
//  Module      : local_eject_port_if
//  Description : Crossbar-side and collector-side handshake bundle of the
//                local ejection port.
//  Ports       : PacketIn/ReqUpStr/UpStrFull - crossbar write side
//                PacketOut/ReqDnStr/GntDnStr/DnStrFull - collector side
//  Modports    : slave  - the ejection port itself
//                master - the environment (crossbar + collector)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface local_eject_port_if
   import noc_pkg::*;
#(
   parameter int dataWidth = DATA_WIDTH_DEF
) ();

   logic [dataWidth-1:0] PacketIn;
   logic                 ReqUpStr;
   logic                 UpStrFull;
   logic [dataWidth-1:0] PacketOut;
   logic                 ReqDnStr;
   logic                 GntDnStr;
   logic                 DnStrFull;

   modport slave (
      input  PacketIn, ReqUpStr, GntDnStr, DnStrFull,
      output UpStrFull, PacketOut, ReqDnStr
   );

   modport master (
      output PacketIn, ReqUpStr, GntDnStr, DnStrFull,
      input  UpStrFull, PacketOut, ReqDnStr
   );

endinterface : local_eject_port_if

`default_nettype wire

// File: rtl/eject_fifo.sv
// ============================================================================
//  Module      : eject_fifo
//  Description : depth-entry packet FIFO with registered full flag and
//                occupancy count. Storage is not reset.
//  Ports       : clk, reset (sync, active-low)
//                push/din  - write request and data (ignored while full)
//                pop       - remove head entry (ignored while empty)
//                head      - current head entry
//                count     - occupancy, full (registered), empty
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eject_fifo
   import noc_pkg::*;
#(
   parameter int dataWidth = DATA_WIDTH_DEF,
   parameter int depth     = DEPTH_DEF,
   localparam int AW       = $clog2(depth),
   localparam int CW       = $clog2(depth + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [dataWidth-1:0] din,
   output logic [dataWidth-1:0] head,
   output logic [CW-1:0]        count,
   output logic                 full,
   output logic                 empty
);

   logic [dataWidth-1:0] mem [depth];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full_q, full_d;
   logic                 push_ok, pop_ok;

   // Full gates the write, so a push+pop while full degenerates to a pop.
   // Pointers are AW bits wide and wrap naturally because depth is 2**AW.
   always_comb begin
      push_ok  = push && !full_q;
      pop_ok   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(depth));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // A write landing during reset is harmless: the pointers are cleared, so
   // the entry is never presented.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= din;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = (count_q == '0);

endmodule : eject_fifo

`default_nettype wire

// File: rtl/local_eject_port.sv
// ============================================================================
//  Module      : local_eject_port
//  Description : Router local ejection port. Buffers packets from the crossbar
//                local output and hands them to the collector with a
//                REQ / grant-pulse / ACK handshake (one packet per 3 cycles).
//  Ports       : clk, reset (sync, active-low)
//                bus (local_eject_port_if.slave) - crossbar and collector
//                EjectCount, StallCount, DropCount - only with EJECT_STATS_EN
//  Config      : EJECT_STATS_EN - adds saturating eject/stall/drop counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module local_eject_port
   import noc_pkg::*;
#(
   parameter int         dataWidth = DATA_WIDTH_DEF,
   parameter int         depth     = DEPTH_DEF,
   parameter logic [5:0] routerID  = 6'b000_000
) (
   input  logic         clk,
   input  logic         reset,
   local_eject_port_if.slave bus
`ifdef EJECT_STATS_EN
   ,
   output logic [31:0]  EjectCount,
   output logic [31:0]  StallCount,
   output logic [15:0]  DropCount
`endif
);

   localparam int CW = $clog2(depth + 1);

   if ((depth < 2) || ((depth & (depth - 1)) != 0) || ($bits(routerID) != 6))
   begin : g_param_check
      $error("local_eject_port: depth must be a power of two >= 2");
   end

   eject_state_e         state_q, state_d;
   logic                 req_q, req_d;
   logic                 pop;
   logic                 has_data;
   logic [dataWidth-1:0] fifo_head;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;

   eject_fifo #(
      .dataWidth (dataWidth),
      .depth     (depth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.ReqUpStr),
      .pop   (pop),
      .din   (bus.PacketIn),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The grant is honoured only in REQ; in IDLE/ACK it is ignored.
   // DnStrFull only blocks entry into REQ, never withdraws a pending request.
   always_comb begin
      has_data = (fifo_count != '0);
      pop      = (state_q == REQ) && bus.GntDnStr && !fifo_empty;
      state_d  = state_q;
      case (state_q)
         IDLE:    if (has_data && !bus.DnStrFull) state_d = REQ;
         REQ:     if (bus.GntDnStr) state_d = ACK;
         ACK:     state_d = (has_data && !bus.DnStrFull) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   assign bus.UpStrFull = fifo_full;
   assign bus.PacketOut = fifo_head;
   assign bus.ReqDnStr  = req_q;

`ifdef EJECT_STATS_EN
   logic [31:0] eject_q, eject_d;
   logic [31:0] stall_q, stall_d;
   logic [15:0] drop_q,  drop_d;

   // All counters saturate at all-ones.
   always_comb begin
      eject_d = eject_q;
      stall_d = stall_q;
      drop_d  = drop_q;
      if (pop && (eject_q != '1)) eject_d = eject_q + 32'd1;
      if ((state_q == REQ) && !bus.GntDnStr && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (bus.ReqUpStr && fifo_full && (drop_q != '1)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         eject_q <= '0;
         stall_q <= '0;
         drop_q  <= '0;
      end else begin
         eject_q <= eject_d;
         stall_q <= stall_d;
         drop_q  <= drop_d;
      end
   end

   assign EjectCount = eject_q;
   assign StallCount = stall_q;
   assign DropCount  = drop_q;
`endif

endmodule : local_eject_port

`default_nettype wire

// File: tb/tb_local_eject_port.sv
// ============================================================================
//  Module      : tb_local_eject_port
//  Description : Self-checking bench for local_eject_port. A queue model of
//                the buffer plus a registered-grant collector model predict
//                every ejected packet, the full flag and the statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_local_eject_port;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   local_eject_port_if #(.dataWidth(DW)) bus ();

`ifdef EJECT_STATS_EN
   logic [31:0] EjectCount;
   logic [31:0] StallCount;
   logic [15:0] DropCount;
`endif

   local_eject_port #(
      .dataWidth (DW),
      .depth     (DEPTH),
      .routerID  (6'b000_000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef EJECT_STATS_EN
      ,
      .EjectCount (EjectCount),
      .StallCount (StallCount),
      .DropCount  (DropCount)
`endif
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [DW-1:0] mq[$];
   bit          auto_col = 0;
   logic        s_req, s_full, s_gnt;
   logic [DW-1:0] s_pkt;
   bit          did_pop, did_wr;
   logic [DW-1:0] pop_model, pop_dut;
   longint      exp_eject = 0, exp_stall = 0, exp_drop = 0;
   int          cyc = 0;

   // One clock: sample pre-edge values on the falling edge, then update the
   // model just after the rising edge. The collector model grants one cycle
   // after it sees a request and releases after one cycle.
   task automatic tick();
      bit wr, pp, drop;
      logic [DW-1:0] din;
      @(negedge clk);
      s_req = bus.ReqDnStr;
      s_full = bus.UpStrFull;
      s_pkt = bus.PacketOut;
      s_gnt = bus.GntDnStr;
      din = bus.PacketIn;
      wr = reset && bus.ReqUpStr && !s_full;
      pp = reset && s_req && s_gnt;
      drop = reset && bus.ReqUpStr && s_full;
      @(posedge clk);
      #1;
      cyc++;
      did_pop = 0;
      did_wr = 0;
      if (!reset) begin
         mq.delete();
         exp_eject = 0;
         exp_stall = 0;
         exp_drop = 0;
      end else begin
         if (pp) begin
            did_pop = 1;
            pop_dut = s_pkt;
            pop_model = (mq.size() > 0) ? mq.pop_front() : 'x;
            exp_eject++;
         end
         if (wr) begin
            mq.push_back(din);
            did_wr = 1;
         end
         if (s_req && !s_gnt) exp_stall++;
         if (drop) exp_drop++;
      end
      if (auto_col) bus.GntDnStr = s_req && !s_gnt;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      auto_col = 0;
      bus.ReqUpStr = 1'b0;
      bus.GntDnStr = 1'b0;
      bus.DnStrFull = 1'b0;
      bus.PacketIn = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic write_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.PacketIn = $urandom;
         bus.ReqUpStr = 1'b1;
         tick();
      end
      bus.ReqUpStr = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      n_cmp++; if (bus.ReqDnStr !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.ReqDnStr); end
      n_cmp++; if (bus.UpStrFull !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.UpStrFull); end
      n_cmp++; if (dut.fifo_count !== CW'(0)) begin n_bad++; $display("FAIL reset_count: got %0d want 0", dut.fifo_count); end
`ifdef EJECT_STATS_EN
      n_cmp++; if ({EjectCount, StallCount, DropCount} !== 80'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", EjectCount, StallCount, DropCount); end
`endif
   endtask

   task automatic test_single();
      pulse_reset();
      bus.PacketIn = 32'h0000_A5C3;
      bus.ReqUpStr = 1'b1;
      tick();
      bus.ReqUpStr = 1'b0;
      n_cmp++; if (bus.ReqDnStr !== 1'b0) begin n_bad++; $display("FAIL single_req_edge0: got %b want 0", bus.ReqDnStr); end
      tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b1) begin n_bad++; $display("FAIL single_req_edge1: got %b want 1", bus.ReqDnStr); end
      n_cmp++; if (bus.PacketOut !== 32'h0000_A5C3) begin n_bad++; $display("FAIL single_pkt: got %h want 0000a5c3", bus.PacketOut); end
      bus.GntDnStr = 1'b1;
      tick();
      bus.GntDnStr = 1'b0;
      n_cmp++; if (!did_pop || pop_dut !== 32'h0000_A5C3) begin n_bad++; $display("FAIL single_pop: popped %0d data %h want 1 a5c3", did_pop, pop_dut); end
      n_cmp++; if (bus.ReqDnStr !== 1'b0) begin n_bad++; $display("FAIL single_ack: got %b want 0", bus.ReqDnStr); end
      tick();
      tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b0 || dut.fifo_count !== CW'(0)) begin n_bad++; $display("FAIL single_idle: req %b count %0d want 0 0", bus.ReqDnStr, dut.fifo_count); end
   endtask

   task automatic test_fill();
      int pops = 0;
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         bus.PacketIn = $urandom;
         bus.ReqUpStr = 1'b1;
         tick();
         if (i == 3) begin
            n_cmp++; if (bus.UpStrFull !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", bus.UpStrFull); end
         end
      end
      bus.ReqUpStr = 1'b0;
      n_cmp++; if (dut.fifo_count !== CW'(4)) begin n_bad++; $display("FAIL fill_count: got %0d want 4", dut.fifo_count); end
`ifdef EJECT_STATS_EN
      n_cmp++; if (DropCount !== 16'd1) begin n_bad++; $display("FAIL fill_drop: got %0d want 1", DropCount); end
`endif
      auto_col = 1;
      for (int k = 0; k < 40 && mq.size() > 0; k++) begin
         tick();
         if (did_pop) begin
            pops++;
            n_cmp++; if (pop_dut !== pop_model) begin n_bad++; $display("FAIL fill_order: got %h want %h", pop_dut, pop_model); end
         end
      end
      n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL fill_pops: got %0d want 4", pops); end
   endtask

   task automatic test_drain();
      int pc[4];
      int np = 0;
      pulse_reset();
      bus.DnStrFull = 1'b1;
      write_n(4);
      n_cmp++; if (bus.UpStrFull !== 1'b1) begin n_bad++; $display("FAIL drain_full: got %b want 1", bus.UpStrFull); end
      bus.DnStrFull = 1'b0;
      auto_col = 1;
      for (int k = 0; k < 30 && np < 4; k++) begin
         tick();
         if (did_pop) begin
            pc[np] = cyc;
            if (np == 0) begin
               n_cmp++; if (bus.UpStrFull !== 1'b0) begin n_bad++; $display("FAIL drain_full_clear: got %b want 0", bus.UpStrFull); end
            end
            np++;
            n_cmp++; if (pop_dut !== pop_model) begin n_bad++; $display("FAIL drain_order: got %h want %h", pop_dut, pop_model); end
         end
      end
      n_cmp++; if (np != 4) begin n_bad++; $display("FAIL drain_pops: got %0d want 4", np); end
      for (int j = 1; j < np; j++) begin
         n_cmp++; if (pc[j] - pc[j-1] != 3) begin n_bad++; $display("FAIL drain_rate: gap %0d want 3", pc[j] - pc[j-1]); end
      end
`ifdef EJECT_STATS_EN
      n_cmp++; if (EjectCount !== 32'd4) begin n_bad++; $display("FAIL drain_eject: got %0d want 4", EjectCount); end
`endif
   endtask

   task automatic test_backpressure();
      pulse_reset();
      bus.DnStrFull = 1'b1;
      write_n(2);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if (bus.ReqDnStr !== 1'b0) begin n_bad++; $display("FAIL bp_req_held: got %b want 0", bus.ReqDnStr); end
      end
      bus.GntDnStr = 1'b1;
      tick();
      bus.GntDnStr = 1'b0;
      n_cmp++; if (did_pop || dut.fifo_count !== CW'(2)) begin n_bad++; $display("FAIL bp_spurious: pop %0d count %0d want 0 2", did_pop, dut.fifo_count); end
      bus.DnStrFull = 1'b0;
      tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", bus.ReqDnStr); end
      n_cmp++; if (bus.PacketOut !== mq[0]) begin n_bad++; $display("FAIL bp_head: got %h want %h", bus.PacketOut, mq[0]); end
   endtask

   task automatic test_simul();
      int written = 0;
      pulse_reset();
      write_n(4);
      written = 4;
      n_cmp++; if (bus.ReqDnStr !== 1'b1 || bus.UpStrFull !== 1'b1) begin n_bad++; $display("FAIL simul_setup: req %b full %b want 1 1", bus.ReqDnStr, bus.UpStrFull); end
      bus.GntDnStr = 1'b1;
      bus.ReqUpStr = 1'b1;
      bus.PacketIn = $urandom;
      tick();
      bus.GntDnStr = 1'b0;
      n_cmp++; if (!did_pop || pop_dut !== pop_model) begin n_bad++; $display("FAIL simul_pop: pop %0d got %h want %h", did_pop, pop_dut, pop_model); end
      n_cmp++; if (dut.fifo_count !== CW'(3)) begin n_bad++; $display("FAIL simul_reject: got %0d want 3", dut.fifo_count); end
      tick();
      bus.ReqUpStr = 1'b0;
      if (did_wr) written++;
      n_cmp++; if (dut.fifo_count !== CW'(4) || bus.UpStrFull !== 1'b1) begin n_bad++; $display("FAIL simul_accept: count %0d full %b want 4 1", dut.fifo_count, bus.UpStrFull); end
      auto_col = 1;
      for (int k = 0; k < 200 && (written < 10 || mq.size() > 0); k++) begin
         bus.ReqUpStr = (written < 10);
         bus.PacketIn = $urandom;
         tick();
         if (did_wr) written++;
         if (did_pop) begin
            n_cmp++; if (pop_dut !== pop_model) begin n_bad++; $display("FAIL simul_wrap: got %h want %h", pop_dut, pop_model); end
         end
      end
      bus.ReqUpStr = 1'b0;
      n_cmp++; if (written != 10 || dut.fifo_count !== CW'(0)) begin n_bad++; $display("FAIL simul_total: written %0d count %0d want 10 0", written, dut.fifo_count); end
   endtask

   task automatic test_midreset();
      pulse_reset();
      write_n(3);
      for (int k = 0; k < 10 && bus.ReqDnStr !== 1'b1; k++) tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got %b want 1", bus.ReqDnStr); end
      reset = 1'b0;
      bus.GntDnStr = 1'b1;
      tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b0 || bus.UpStrFull !== 1'b0) begin n_bad++; $display("FAIL mid_outputs: req %b full %b want 0 0", bus.ReqDnStr, bus.UpStrFull); end
      n_cmp++; if (dut.fifo_count !== CW'(0)) begin n_bad++; $display("FAIL mid_count: got %0d want 0", dut.fifo_count); end
`ifdef EJECT_STATS_EN
      n_cmp++; if (EjectCount !== 32'd0 || StallCount !== 32'd0) begin n_bad++; $display("FAIL mid_stats: got %0d/%0d want 0/0", EjectCount, StallCount); end
`endif
      reset = 1'b1;
      bus.GntDnStr = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.ReqDnStr !== 1'b0) begin n_bad++; $display("FAIL mid_after: got %b want 0", bus.ReqDnStr); end
   endtask

   task automatic test_random();
      pulse_reset();
      auto_col = 1;
      for (int k = 0; k < 600; k++) begin
         bus.ReqUpStr = 1'($urandom_range(0, 1));
         bus.PacketIn = $urandom;
         bus.DnStrFull = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 99) != 0);
         tick();
         n_cmp++; if (bus.UpStrFull !== (mq.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_full: got %b model size %0d", bus.UpStrFull, mq.size()); end
         n_cmp++; if (dut.fifo_count !== CW'(mq.size())) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", dut.fifo_count, mq.size()); end
         if (did_pop) begin
            n_cmp++; if (pop_dut !== pop_model) begin n_bad++; $display("FAIL rnd_order: got %h want %h", pop_dut, pop_model); end
         end
         if (bus.ReqDnStr === 1'b1) begin
            n_cmp++; if (mq.size() == 0 || bus.PacketOut !== mq[0]) begin n_bad++; $display("FAIL rnd_head: got %h size %0d", bus.PacketOut, mq.size()); end
         end
      end
      reset = 1'b1;
`ifdef EJECT_STATS_EN
      n_cmp++; if (EjectCount !== 32'(exp_eject) || StallCount !== 32'(exp_stall) || DropCount !== 16'(exp_drop)) begin
         n_bad++; $display("FAIL rnd_stats: got %0d/%0d/%0d want %0d/%0d/%0d", EjectCount, StallCount, DropCount, exp_eject, exp_stall, exp_drop);
      end
`endif
   endtask

   initial begin
      reset = 1'b0;
      bus.ReqUpStr = 1'b0;
      bus.GntDnStr = 1'b0;
      bus.DnStrFull = 1'b0;
      bus.PacketIn = '0;
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_backpressure();
      test_simul();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_local_eject_port

`default_nettype wire
